// File: rtl/cache_arbiter_pkg.sv
// ============================================================================
// Module  : cache_arbiter_pkg
// Brief   : Shared types for the I/D-cache to memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_grant;

endpackage

`default_nettype wire

// File: rtl/cache_arb_pick.sv
// ============================================================================
// Module  : cache_arb_pick
// Brief   : Combinational grant selection; round-robin under ARB_RR_EN,
//           fixed D-over-I priority otherwise.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_arb_pick
    import cache_arbiter_pkg::*;
(
    input  logic      i_req,
    input  logic      d_req,
    input  lc3b_grant last_grant,
    output logic      grant_valid,
    output lc3b_grant grant
);

    assign grant_valid = i_req | d_req;

`ifdef ARB_RR_EN
    always_comb begin
        grant = GRANT_I;
        if (i_req && d_req)
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        else if (d_req)
            grant = GRANT_D;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = d_req ? GRANT_D : GRANT_I;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// Module  : cache_arbiter
// Brief   : Shares one memory line port between I-cache and D-cache misses.
//           Optional macro ARB_RR_EN enables round-robin arbitration.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    lc3b_arb_state state;
    lc3b_grant     last_grant;
    lc3b_grant     grant;
    logic          grant_valid;
    logic          d_req;

    assign d_req = d_read | d_write;

    cache_arb_pick u_pick (
        .i_req       (i_read),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= GRANT_I;
        else if (state == ARB_IDLE && grant_valid)
            last_grant <= grant;
    end
`else
    assign last_grant = GRANT_I;
`endif

    // Strobes and captured address/data are registered straight onto the
    // memory port, so requester changes during a transfer are invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        if (grant == GRANT_D) begin
                            state       <= ARB_D;
                            mem_address <= d_address;
                            mem_wdata   <= d_wdata;
                            mem_read    <= ~d_write;
                            mem_write   <= d_write;
                        end else begin
                            state       <= ARB_I;
                            mem_address <= i_address;
                            mem_read    <= 1'b1;
                            mem_write   <= 1'b0;
                        end
                    end
                end
                ARB_I, ARB_D: begin
                    if (mem_resp) begin
                        state     <= ARB_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign i_resp  = (state == ARB_I) && mem_resp;
    assign d_resp  = (state == ARB_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(d_read && d_write));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// Module  : tb_cache_arbiter
// Brief   : Directed self-checking bench for cache_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_resp;

    int checks = 0;
    int passed = 0;

    logic [127:0] pat_a5;
    logic [127:0] pat_dead;
    logic [127:0] pat_5a;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the granting edge; returns in the idle cycle.
    task automatic serve(input string tag, input logic [15:0] exp_addr, input logic exp_d);
        check({tag, "_addr"}, 128'(mem_address), 128'(exp_addr));
        check({tag, "_read"}, 128'(mem_read), 128'(1'b1));
        mem_resp  = 1'b1;
        mem_rdata = pat_5a;
        #1;
        check({tag, "_iresp"}, 128'(i_resp), 128'(!exp_d));
        check({tag, "_dresp"}, 128'(d_resp), 128'(exp_d));
        tick();
        mem_resp = 1'b0;
        #1;
        check({tag, "_idle"}, 128'(mem_read), 128'(1'b0));
    endtask

    initial begin
        pat_a5    = {16{8'hA5}};
        pat_dead  = {8{16'hDEAD}};
        pat_5a    = {16{8'h5A}};
        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mem_read",  128'(mem_read),    128'(0));
        check("rst_mem_write", 128'(mem_write),   128'(0));
        check("rst_mem_addr",  128'(mem_address), 128'(0));
        check("rst_mem_wdata", mem_wdata,         128'(0));
        check("rst_i_resp",    128'(i_resp),      128'(0));
        check("rst_d_resp",    128'(d_resp),      128'(0));

        // I-cache read, memory answers in the third strobe cycle
        i_read    = 1'b1;
        i_address = 16'h1230;
        tick();
        check("i_c1_read", 128'(mem_read),    128'(1));
        check("i_c1_addr", 128'(mem_address), 128'(16'h1230));
        check("i_c1_wr",   128'(mem_write),   128'(0));
        check("i_c1_iresp", 128'(i_resp),     128'(0));
        tick();
        check("i_c2_read", 128'(mem_read), 128'(1));
        tick();
        check("i_c3_read", 128'(mem_read), 128'(1));
        mem_resp  = 1'b1;
        mem_rdata = pat_a5;
        #1;
        check("i_resp",  128'(i_resp), 128'(1));
        check("i_rdata", i_rdata,      pat_a5);
        check("i_dresp", 128'(d_resp), 128'(0));
        i_read = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        check("i_done_read", 128'(mem_read), 128'(0));
        check("i_done_resp", 128'(i_resp),   128'(0));

        // D-cache writeback, data changed after grant
        d_write   = 1'b1;
        d_address = 16'h4000;
        d_wdata   = pat_dead;
        tick();
        check("dw_write", 128'(mem_write),   128'(1));
        check("dw_read",  128'(mem_read),    128'(0));
        check("dw_addr",  128'(mem_address), 128'(16'h4000));
        d_wdata   = '0;
        d_address = 16'h7777;
        tick();
        check("dw_hold_data", mem_wdata,          pat_dead);
        check("dw_hold_addr", 128'(mem_address),  128'(16'h4000));
        check("dw_hold_read", 128'(mem_read),     128'(0));
        mem_resp = 1'b1;
        #1;
        check("dw_dresp", 128'(d_resp), 128'(1));
        check("dw_iresp", 128'(i_resp), 128'(0));
        d_write = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        check("dw_done_write", 128'(mem_write), 128'(0));

        // Simultaneous requests from reset: last_grant starts as I
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        i_read    = 1'b1;
        i_address = 16'h1111;
        d_read    = 1'b1;
        d_address = 16'h2222;
        tick();
        serve("pair1", 16'h2222, 1'b1);
        check("pair_gap_read", 128'(mem_read), 128'(0));
        d_address = 16'h2230;
        tick();
`ifdef ARB_RR_EN
        serve("pair2", 16'h1111, 1'b0);
        i_read = 1'b0;
        tick();
        serve("pair3", 16'h2230, 1'b1);
        d_read = 1'b0;
`else
        serve("pair2", 16'h2230, 1'b1);
        d_read = 1'b0;
        tick();
        serve("pair3", 16'h1111, 1'b0);
        i_read = 1'b0;
`endif

        // Reset in the middle of a D transfer
        tick();
        d_read    = 1'b1;
        d_address = 16'h3000;
        tick();
        check("rstmid_read", 128'(mem_read), 128'(1));
        rst    = 1'b1;
        d_read = 1'b0;
        tick();
        rst = 1'b0;
        check("rstmid_drop_read",  128'(mem_read),    128'(0));
        check("rstmid_drop_write", 128'(mem_write),   128'(0));
        check("rstmid_addr",       128'(mem_address), 128'(0));
        check("rstmid_dresp",      128'(d_resp),      128'(0));

        // Stray mem_resp while idle
        mem_resp = 1'b1;
        #1;
        check("stray_iresp", 128'(i_resp), 128'(0));
        check("stray_dresp", 128'(d_resp), 128'(0));
        tick();
        mem_resp = 1'b0;
        check("stray_idle_read", 128'(mem_read), 128'(0));
        i_read    = 1'b1;
        i_address = 16'h0040;
        tick();
        serve("after_stray", 16'h0040, 1'b0);
        i_read = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
